nic_buffered: RTL and testbench

Parametrised successor to the single-entry network interface controller. Sits between a processing element's load/store port and a mesh router's PE port. Each direction gets a configurable-depth FIFO, so the CPU can queue several outgoing packets and the router can deliver several incoming packets before the CPU drains them. Outgoing launch is gated by the router's polarity (virtual-channel phase).

---
 rtl/nic_pkg.sv | 29 ++
 rtl/nic_sync_fifo.sv | 80 ++++++++
 rtl/nic_buffered.sv | 156 +++++++++++++++
 tb/tb_nic_buffered.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nic_pkg.sv
// nic_pkg
// Shared definitions for the buffered network interface controller.
//   - CPU register map addresses (input/output buffer and status words)
//   - VC_BIT: bit index of the virtual-channel bit in a packet.
//     Bit 0 is the MSB because packets use ascending [0:N-1] ranges.
//   - statusCountOffset(): the left shift that places the FIFO count
//     field inside a status word.
// Configuration macro: NIC_ERR_EN. When it is defined, status words carry
// a sticky error flag in bit 1, and the count field moves up by one bit.
package nic_pkg;

  localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  localparam int VC_BIT = 0;

  // Bit 0 of a status word is always the low status bit (nonempty/full).
  // With error flags enabled, bit 1 holds the flag, so the count starts at bit 2.
  function automatic int statusCountOffset();
`ifdef NIC_ERR_EN
    return 2;
`else
    return 1;
`endif
  endfunction

endpackage

// File: rtl/nic_sync_fifo.sv
// nic_sync_fifo
// Single-clock FIFO with a synchronous active-high reset. One instance
// buffers each NIC direction.
// Ports:
//   clk, reset        clock and synchronous reset (reset empties the FIFO)
//   i_push, i_wrData  write request and data; ignored when the FIFO is full
//   i_pop             read request; ignored when the FIFO is empty
//   o_rdData          current head entry (undefined content when empty)
//   o_full, o_empty   occupancy flags, derived from the count
//   o_count           number of stored entries, 0..DEPTH
// DEPTH must be a power of two and at least 2, so the pointers wrap
// naturally modulo DEPTH.
module nic_sync_fifo
  import nic_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_wrData,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_rdData,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  // Full and empty come from the pre-edge count. This rule gates both
  // requests, so a push into a full FIFO is dropped even if a pop happens
  // in the same cycle.
  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_rdData = r_mem[r_rdPtr];
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  // The storage array has no reset. Reset flushes the FIFO through the
  // pointers and count alone.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_wrData;
    end
  end

  // Pointer and occupancy bookkeeping. A push and a pop in the same cycle
  // both take effect and leave the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/nic_buffered.sv
// nic_buffered
// Network interface controller between a PE load/store port and a mesh
// router PE port. Each direction has its own FIFO.
// Ports:
//   clk, reset               clock and synchronous active-high reset
//   addr, d_in, nicEn,       CPU register access: 00 input buffer,
//   nicEnWR                  01 input status, 10 output buffer, 11 output status
//   d_out                    registered CPU load data
//   net_si, net_di, net_ro   router-to-NIC packet handshake
//   net_so, net_do, net_ri   NIC-to-router packet handshake
//   net_polarity             router VC phase; gates outgoing launch
// Configuration macro: NIC_ERR_EN. It adds sticky overflow and underflow
// flags, reported in the status words.
module nic_buffered
  import nic_pkg::*;
#(
  parameter int PACKET_WIDTH = 64,
  parameter int IN_DEPTH     = 4,
  parameter int OUT_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [0:1]              addr,
  input  logic [0:PACKET_WIDTH-1] d_in,
  output logic [0:PACKET_WIDTH-1] d_out,
  input  logic                    nicEn,
  input  logic                    nicEnWR,
  input  logic                    net_si,
  input  logic [0:PACKET_WIDTH-1] net_di,
  output logic                    net_ro,
  output logic                    net_so,
  output logic [0:PACKET_WIDTH-1] net_do,
  input  logic                    net_ri,
  input  logic                    net_polarity
);

  localparam int IN_CNT_W  = $clog2(IN_DEPTH + 1);
  localparam int OUT_CNT_W = $clog2(OUT_DEPTH + 1);

  logic [0:PACKET_WIDTH-1] w_inHead;
  logic [0:PACKET_WIDTH-1] w_outRaw;
  logic [0:PACKET_WIDTH-1] w_outHead;
  logic [0:PACKET_WIDTH-1] w_inStat;
  logic [0:PACKET_WIDTH-1] w_outStat;
  logic                    w_inFull;
  logic                    w_inEmpty;
  logic                    w_outFull;
  logic                    w_outEmpty;
  logic [IN_CNT_W-1:0]     w_inCount;
  logic [OUT_CNT_W-1:0]    w_outCount;
  logic                    w_inPush;
  logic                    w_inPop;
  logic                    w_outStore;
  logic                    w_outPop;
  logic                    w_load;

  assign w_load     = nicEn && !nicEnWR;
  assign w_outStore = nicEn && nicEnWR && (addr == ADDR_OUT_BUF);
  assign w_inPush   = net_si && net_ro;
  assign w_inPop    = w_load && (addr == ADDR_IN_BUF) && !w_inEmpty;

  // The router always sees the output head, forced to zero when nothing is
  // queued. A packet launches only when its VC bit matches the current phase.
  assign net_ro    = !w_inFull;
  assign w_outHead = w_outEmpty ? '0 : w_outRaw;
  assign net_do    = w_outHead;
  assign net_so    = !w_outEmpty && net_ri && (w_outHead[VC_BIT] == net_polarity);
  assign w_outPop  = net_so;

  nic_sync_fifo #(
    .WIDTH (PACKET_WIDTH),
    .DEPTH (IN_DEPTH)
  ) u_inFifo (
    .clk      (clk),
    .reset    (reset),
    .i_push   (w_inPush),
    .i_wrData (net_di),
    .i_pop    (w_inPop),
    .o_rdData (w_inHead),
    .o_full   (w_inFull),
    .o_empty  (w_inEmpty),
    .o_count  (w_inCount)
  );

  nic_sync_fifo #(
    .WIDTH (PACKET_WIDTH),
    .DEPTH (OUT_DEPTH)
  ) u_outFifo (
    .clk      (clk),
    .reset    (reset),
    .i_push   (w_outStore),
    .i_wrData (d_in),
    .i_pop    (w_outPop),
    .o_rdData (w_outRaw),
    .o_full   (w_outFull),
    .o_empty  (w_outEmpty),
    .o_count  (w_outCount)
  );

`ifdef NIC_ERR_EN
  logic r_ovf;
  logic r_unf;
  logic w_ovfSet;
  logic w_unfSet;
  logic w_ovfClr;
  logic w_unfClr;

  assign w_ovfSet = w_outStore && w_outFull;
  assign w_unfSet = w_load && (addr == ADDR_IN_BUF) && w_inEmpty;
  assign w_ovfClr = w_load && (addr == ADDR_OUT_STAT);
  assign w_unfClr = w_load && (addr == ADDR_IN_STAT);

  // Sticky error flags. Reading a status word clears the flag it reports,
  // but an error in that same cycle sets the flag again.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= (r_ovf && !w_ovfClr) || w_ovfSet;
      r_unf <= (r_unf && !w_unfClr) || w_unfSet;
    end
  end
`endif

  // Build the status words: count field, optional error flag in bit 1,
  // and the low status bit. Because of the ascending range, the LSB of
  // each word is index PACKET_WIDTH-1.
  always_comb begin
    w_inStat  = PACKET_WIDTH'(w_inCount) << statusCountOffset();
    w_outStat = PACKET_WIDTH'(w_outCount) << statusCountOffset();
    w_inStat[PACKET_WIDTH-1]  = !w_inEmpty;
    w_outStat[PACKET_WIDTH-1] = w_outFull;
`ifdef NIC_ERR_EN
    w_inStat[PACKET_WIDTH-2]  = r_unf;
    w_outStat[PACKET_WIDTH-2] = r_ovf;
`endif
  end

  // CPU load register. A status load captures the pre-edge state, which
  // gives one cycle of status latency. A load from the output-buffer
  // address leaves d_out as it was.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_out <= '0;
    end else if (w_load) begin
      case (addr)
        ADDR_IN_BUF:   d_out <= w_inEmpty ? '0 : w_inHead;
        ADDR_IN_STAT:  d_out <= w_inStat;
        ADDR_OUT_STAT: d_out <= w_outStat;
        default:       d_out <= d_out;
      endcase
    end
  end

endmodule

// File: tb/tb_nic_buffered.sv
// tb_nic_buffered
// Testbench for nic_buffered. It runs directed scenarios, then random
// traffic, and checks the DUT against a queue-based reference model.
// When NIC_ERR_EN is defined, the expected status words include the
// error flags.
module tb_nic_buffered;

`ifdef NIC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int IN_DEPTH  = 4;
  localparam int OUT_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicEnWR;
  logic        net_si;
  logic [63:0] net_di;
  logic        net_ro;
  logic        net_so;
  logic [63:0] net_do;
  logic        net_ri;
  logic        net_polarity;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [63:0] inQ[$];
  logic [63:0] outQ[$];
  bit          mOvf;
  bit          mUnf;
  logic [63:0] mDout;

  logic [63:0] pkts [4];
  logic [63:0] stores [5];

  nic_buffered #(
    .PACKET_WIDTH (64),
    .IN_DEPTH     (IN_DEPTH),
    .OUT_DEPTH    (OUT_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicEnWR      (nicEnWR),
    .net_si       (net_si),
    .net_di       (net_di),
    .net_ro       (net_ro),
    .net_so       (net_so),
    .net_do       (net_do),
    .net_ri       (net_ri),
    .net_polarity (net_polarity)
  );

  always #5 clk = ~clk;

  // Status word: count field, then the optional error flag, then the low bit.
  function automatic logic [63:0] statusWord(int cnt, bit flag, bit low);
    if (ERR_EN) return 64'(cnt * 4 + (flag ? 2 : 0) + (low ? 1 : 0));
    return 64'(cnt * 2 + (low ? 1 : 0));
  endfunction

  task automatic checkOutput(string tag, logic [63:0] observed, logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs and check the combinational router outputs
  // before the edge. Then advance the model with the rules of the NIC
  // and check d_out after the edge.
  task automatic applyStimulus(input logic en, input logic wr, input logic [1:0] a,
                               input logic [63:0] din, input logic si,
                               input logic [63:0] di, input logic ri, input logic pol);
    logic        expRo;
    logic        expSo;
    logic [63:0] head;
    logic [63:0] newDout;
    bit          popIn;
    bit          pushIn;
    bit          pushOut;
    bit          ovfSet;
    bit          unfSet;
    bit          ovfClr;
    bit          unfClr;
    nicEn = en; nicEnWR = wr; addr = a; d_in = din;
    net_si = si; net_di = di; net_ri = ri; net_polarity = pol;
    #1;
    expRo = (inQ.size() < IN_DEPTH);
    head  = (outQ.size() > 0) ? outQ[0] : 64'd0;
    expSo = (outQ.size() > 0) && ri && (head[63] == pol);
    checkOutput("net_ro", {63'd0, net_ro}, {63'd0, expRo});
    checkOutput("net_so", {63'd0, net_so}, {63'd0, expSo});
    checkOutput("net_do", net_do, head);
    pushIn  = si && expRo;
    pushOut = en && wr && (a == 2'b10) && (outQ.size() < OUT_DEPTH);
    ovfSet  = en && wr && (a == 2'b10) && (outQ.size() == OUT_DEPTH);
    newDout = mDout;
    popIn = 0; unfSet = 0; ovfClr = 0; unfClr = 0;
    if (en && !wr) begin
      case (a)
        2'b00: begin
          if (inQ.size() > 0) begin
            newDout = inQ[0];
            popIn = 1;
          end else begin
            newDout = 64'd0;
            unfSet = 1;
          end
        end
        2'b01: begin
          newDout = statusWord(inQ.size(), mUnf, inQ.size() > 0);
          unfClr = 1;
        end
        2'b11: begin
          newDout = statusWord(outQ.size(), mOvf, outQ.size() == OUT_DEPTH);
          ovfClr = 1;
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    if (popIn) void'(inQ.pop_front());
    if (pushIn) inQ.push_back(di);
    if (expSo) void'(outQ.pop_front());
    if (pushOut) outQ.push_back(din);
    mOvf  = (mOvf && !ovfClr) || ovfSet;
    mUnf  = (mUnf && !unfClr) || unfSet;
    mDout = newDout;
    checkOutput("d_out", d_out, mDout);
  endtask

  // Reset while a router push and a CPU store are being offered. Neither
  // may land, and every output must return to its idle value.
  task automatic doReset();
    reset = 1'b1;
    nicEn = 1'b1; nicEnWR = 1'b1; addr = 2'b10; d_in = 64'h1234;
    net_si = 1'b1; net_di = 64'h5678; net_ri = 1'b0; net_polarity = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    nicEn = 1'b0; nicEnWR = 1'b0; addr = 2'b00; net_si = 1'b0; net_ri = 1'b1;
    inQ.delete();
    outQ.delete();
    mOvf = 0; mUnf = 0; mDout = 64'd0;
    #1;
    checkOutput("rst_d_out", d_out, 64'd0);
    checkOutput("rst_net_ro", {63'd0, net_ro}, 64'd1);
    checkOutput("rst_net_so", {63'd0, net_so}, 64'd0);
    checkOutput("rst_net_do", net_do, 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    nicEn = 0; nicEnWR = 0; addr = 0; d_in = 0;
    net_si = 0; net_di = 0; net_ri = 0; net_polarity = 0;
    inQ.delete(); outQ.delete(); mOvf = 0; mUnf = 0; mDout = 0;
    repeat (3) @(posedge clk);
    #1;
    doReset();

    // Both status words read zero after reset.
    applyStimulus(1, 0, 2'b01, 0, 0, 0, 1, 0);
    checkOutput("rst_in_stat", d_out, 64'd0);
    applyStimulus(1, 0, 2'b11, 0, 0, 0, 1, 0);
    checkOutput("rst_out_stat", d_out, 64'd0);

    // A VC-0 store launches in the next cycle, then the output goes idle.
    applyStimulus(1, 1, 2'b10, 64'h200200000000FA50, 0, 0, 1, 0);
    checkOutput("launch_so", {63'd0, net_so}, 64'd1);
    checkOutput("launch_do", net_do, 64'h200200000000FA50);
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 1, 0);
    checkOutput("launch_done", {63'd0, net_so}, 64'd0);

    // A VC-1 packet waits while the polarity is wrong.
    applyStimulus(1, 1, 2'b10, 64'hC000000000000001, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 2'b00, 0, 0, 0, 1, 0);
    checkOutput("vc_hold", {63'd0, net_so}, 64'd0);
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 1, 1);
    checkOutput("vc_popped", {63'd0, net_so}, 64'd0);

    // Fill the input FIFO, then drain it in order and read once past empty.
    for (int i = 0; i < 4; i++) begin
      pkts[i] = {$urandom, $urandom};
      applyStimulus(0, 0, 2'b00, 0, 1, pkts[i], 1, 0);
    end
    checkOutput("in_full_ro", {63'd0, net_ro}, 64'd0);
    applyStimulus(1, 0, 2'b01, 0, 0, 0, 1, 0);
    checkOutput("in_stat_full", d_out, ERR_EN ? 64'd17 : 64'd9);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 2'b00, 0, 0, 0, 1, 0);
      checkOutput("in_order", d_out, pkts[i]);
    end
    applyStimulus(1, 0, 2'b00, 0, 0, 0, 1, 0);
    checkOutput("in_empty_load", d_out, 64'd0);

    // With the router blocked, the fifth store is dropped.
    for (int i = 0; i < 5; i++) begin
      stores[i] = {1'b0, 31'($urandom), $urandom};
      applyStimulus(1, 1, 2'b10, stores[i], 0, 0, 0, 0);
    end
    applyStimulus(1, 0, 2'b11, 0, 0, 0, 0, 0);
    checkOutput("out_stat_ovf", d_out, ERR_EN ? 64'd19 : 64'd9);
    applyStimulus(1, 0, 2'b11, 0, 0, 0, 0, 0);
    checkOutput("out_stat_again", d_out, ERR_EN ? 64'd17 : 64'd9);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 2'b00, 0, 0, 0, 1, 0);
      checkOutput("out_order", net_do, (i < 3) ? stores[i + 1] : 64'd0);
    end

    // Reset with both FIFOs partly full.
    applyStimulus(0, 0, 2'b00, 0, 1, 64'hAAAA, 0, 0);
    applyStimulus(1, 1, 2'b10, 64'h1111, 1, 64'hBBBB, 0, 0);
    applyStimulus(1, 1, 2'b10, 64'h2222, 0, 0, 0, 0);
    doReset();
    applyStimulus(1, 0, 2'b01, 0, 0, 0, 1, 0);
    checkOutput("post_rst_in_stat", d_out, 64'd0);
    applyStimulus(1, 0, 2'b11, 0, 0, 0, 1, 0);
    checkOutput("post_rst_out_stat", d_out, 64'd0);

    // Random traffic on both directions and all register addresses.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom),
                    {$urandom, $urandom}, 1'($urandom), {$urandom, $urandom},
                    $urandom_range(0, 3) != 0, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
